// File: rtl/line_render_pkg.sv
// Shared constants and types for the line renderer and its sprite window.
package line_render_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int SPR_W      = 32;
    localparam int SPR_H      = 32;
    localparam int SPR_W_BITS = $clog2(SPR_W);
    localparam int SPR_H_BITS = $clog2(SPR_H);

    // ROM value meaning "show the background here"
    localparam logic [3:0] TRANSPARENT = 4'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } render_state_t;

endpackage

// File: rtl/sprite_window.sv
// Combinational sprite hit test and sprite ROM address generation.
// Bounds are compared at 11 bits so a sprite placed near column/row 1023
// is clipped at the screen edge instead of wrapping around to 0.
module sprite_window
    import line_render_pkg::*;
(
    input  logic       spr_en,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] spr_x,
    input  logic [9:0] spr_y,
    output logic       hit,
    output logic [9:0] rom_addr
);

    logic [10:0]           x_lo;
    logic [10:0]           x_hi;
    logic [10:0]           y_lo;
    logic [10:0]           y_hi;
    logic                  in_x;
    logic                  in_y;
    logic [SPR_H_BITS-1:0] row_off;
    logic [SPR_W_BITS-1:0] col_off;

    // Window test and in-sprite offsets; the address is forced to 0 on a miss
    always_comb begin
        x_lo     = {1'b0, spr_x};
        x_hi     = {1'b0, spr_x} + 11'(SPR_W);
        y_lo     = {1'b0, spr_y};
        y_hi     = {1'b0, spr_y} + 11'(SPR_H);
        in_x     = ({1'b0, x} >= x_lo) && ({1'b0, x} < x_hi);
        in_y     = ({1'b0, y} >= y_lo) && ({1'b0, y} < y_hi);
        // Offsets are only meaningful inside the window, where they fit the low bits
        row_off  = y[SPR_H_BITS-1:0] - spr_y[SPR_H_BITS-1:0];
        col_off  = x[SPR_W_BITS-1:0] - spr_x[SPR_W_BITS-1:0];
        hit      = spr_en && in_x && in_y;
        rom_addr = hit ? {row_off, col_off} : 10'd0;
    end

endmodule

// File: rtl/line_renderer.sv
// Line renderer: on each accepted line_start, swaps the ping-pong buffer and
// streams one row of background plus a single overlaid sprite into the
// row buffer write port, one pixel per clock.
module line_renderer
    import line_render_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       line_start,
    input  logic [9:0] next_Y,
    input  logic [3:0] bg_color,
    input  logic       sprite_en,
    input  logic [9:0] sprite_X,
    input  logic [9:0] sprite_Y,
    output logic [9:0] rom_addr,
    input  logic [3:0] rom_data,
    output logic       write_en,
    output logic [9:0] write_X,
    output logic [9:0] write_Y,
    output logic [3:0] write_data,
    output logic       select,
    output logic       busy,
    output logic       overrun
);

    render_state_t state_q;
    render_state_t state_d;

    logic [9:0] x_q;
    logic       drain_q;
    logic       fill;
    logic       accept;
    logic       ovr_d;
    logic       win_en;
    logic       hit;

    logic [3:0] bg_q;
    logic       spr_en_q;
    logic [9:0] spr_x_q;
    logic [9:0] spr_y_q;

    logic       vld_p0;
    logic [9:0] x_p0;
    logic       hit_p0;

    // Sprite pixel wins unless it is transparent or outside the window
    function automatic logic [3:0] pick_pixel(input logic       hit_in,
                                              input logic [3:0] rom_in,
                                              input logic [3:0] bg_in);
        return (hit_in && (rom_in != TRANSPARENT)) ? rom_in : bg_in;
    endfunction

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; rows beyond the visible area are accepted but not filled
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (line_start && (next_Y < 10'(V_ACTIVE))) state_d = FILL;
            FILL:    if (x_q == 10'(H_ACTIVE - 1))              state_d = DRAIN;
            DRAIN:   if (drain_q)                                state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM-derived strobes
    always_comb begin
        fill   = (state_q == FILL);
        accept = (state_q == IDLE) && line_start;
        ovr_d  = (state_q != IDLE) && line_start;
        win_en = spr_en_q && fill;
    end

    // Control registers: column counter, drain timer, buffer select, status
    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_q     <= 10'd0;
            drain_q <= 1'b0;
            select  <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            write_Y <= 10'd0;
        end else begin
            overrun <= ovr_d;
            busy    <= (state_d != IDLE);
            drain_q <= (state_q == DRAIN) ? ~drain_q : 1'b0;
            if (accept) begin
                select  <= ~select;
                write_Y <= next_Y;
                x_q     <= 10'd0;
            end else if (fill) begin
                x_q <= x_q + 10'd1;
            end
        end
    end

    // Per-line parameters captured with the accepted line_start
    always_ff @(posedge Clk) begin
        if (accept) begin
            bg_q     <= bg_color;
            spr_en_q <= sprite_en;
            spr_x_q  <= sprite_X;
            spr_y_q  <= sprite_Y;
        end
    end

    sprite_window u_sprite_window (
        .spr_en   (win_en),
        .x        (x_q),
        .y        (write_Y),
        .spr_x    (spr_x_q),
        .spr_y    (spr_y_q),
        .hit      (hit),
        .rom_addr (rom_addr)
    );

    // Stage p0: hold column and hit while the ROM read is in flight
    always_ff @(posedge Clk) begin
        if (Reset) vld_p0 <= 1'b0;
        else       vld_p0 <= fill;
    end

    // Stage p0 data path
    always_ff @(posedge Clk) begin
        x_p0   <= x_q;
        hit_p0 <= hit;
    end

    // Output stage: merge ROM data with background and drive the write port
    always_ff @(posedge Clk) begin
        if (Reset) begin
            write_en   <= 1'b0;
            write_X    <= 10'd0;
            write_data <= 4'd0;
        end else begin
            write_en   <= vld_p0;
            write_X    <= x_p0;
            write_data <= pick_pixel(hit_p0, rom_data, bg_q);
        end
    end

endmodule

// File: tb/tb_line_renderer.sv
// Self-checking bench for line_renderer with a scoreboard of expected writes.
module tb_line_renderer;

    logic       Clk;
    logic       Reset;
    logic       line_start;
    logic [9:0] next_Y;
    logic [3:0] bg_color;
    logic       sprite_en;
    logic [9:0] sprite_X;
    logic [9:0] sprite_Y;
    logic [9:0] rom_addr;
    logic [3:0] rom_data;
    logic       write_en;
    logic [9:0] write_X;
    logic [9:0] write_Y;
    logic [3:0] write_data;
    logic       select;
    logic       busy;
    logic       overrun;

    typedef struct {
        int x;
        int d;
        int y;
        int c;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_sel = 0;

    line_renderer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .line_start (line_start),
        .next_Y     (next_Y),
        .bg_color   (bg_color),
        .sprite_en  (sprite_en),
        .sprite_X   (sprite_X),
        .sprite_Y   (sprite_Y),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .write_en   (write_en),
        .write_X    (write_X),
        .write_Y    (write_Y),
        .write_data (write_data),
        .select     (select),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Synchronous sprite ROM: 7 everywhere except transparent column 5
    initial rom_data = 4'h0;
    always @(posedge Clk) rom_data <= (rom_addr[4:0] == 5'd5) ? 4'h0 : 4'h7;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int model_pix(int x, int y, int bg, int en, int sx, int sy);
        bit h;
        int rv;
        h  = (en != 0) && (y >= sy) && (y < sy + 32) && (x >= sx) && (x < sx + 32);
        rv = ((x - sx) == 5) ? 0 : 7;
        return (h && rv != 0) ? rv : bg;
    endfunction

    // Called at a falling edge; returns with the t+1 cycle on view
    task automatic start_line(input int y, input int bg, input int en,
                              input int sx, input int sy, output int t);
        exp_t e;
        t = cyc;
        next_Y    = 10'(y);
        bg_color  = 4'(bg);
        sprite_en = 1'(en);
        sprite_X  = 10'(sx);
        sprite_Y  = 10'(sy);
        exp_sel   = exp_sel ^ 1;
        if (y < 480) begin
            for (int x = 0; x < 640; x++) begin
                e.x = x;
                e.d = model_pix(x, y, bg, en, sx, sy);
                e.y = y;
                e.c = t + 3 + x;
                sb.push_back(e);
            end
        end
        line_start = 1'b1;
        @(negedge Clk);
        line_start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        repeat (c - cyc) @(negedge Clk);
    endtask

    task automatic finish_line(input int t);
        wait_until(t + 642);
        chk("busy_last_write", busy, 1);
        chk("write_en_last", write_en, 1);
        wait_until(t + 643);
        chk("busy_done", busy, 0);
        chk("write_en_done", write_en, 0);
        chk("sb_drained", sb.size(), 0);
    endtask

    // Write monitor: every strobe must match the next scoreboard entry
    always @(negedge Clk) begin
        if (write_en === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_X", write_X, mon_e.x);
                chk("wr_data", write_data, mon_e.d);
                chk("wr_Y", write_Y, mon_e.y);
                chk("wr_cycle", cyc, mon_e.c);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        int t;
        int t2;
        Reset      = 1'b1;
        line_start = 1'b0;
        next_Y     = '0;
        bg_color   = '0;
        sprite_en  = 1'b0;
        sprite_X   = '0;
        sprite_Y   = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_select", select, 0);
        chk("rst_write_en", write_en, 0);
        chk("rst_write_X", write_X, 0);
        chk("rst_write_Y", write_Y, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);

        // Plain background line
        start_line(10, 3, 0, 0, 0, t);
        chk("t1_select", select, exp_sel);
        chk("t1_busy", busy, 1);
        @(negedge Clk);
        chk("t1_no_early_write", write_en, 0);
        @(negedge Clk);
        chk("t1_first_write", write_en, 1);
        finish_line(t);

        // Sprite row with a transparent column
        start_line(55, 2, 1, 100, 50, t);
        chk("t2_rom_addr_x0", rom_addr, 0);
        wait_until(t + 101);
        chk("t2_rom_addr_x100", rom_addr, 160);
        wait_until(t + 106);
        chk("t2_rom_addr_x105", rom_addr, 165);
        finish_line(t);

        // Right-edge clipping, row just above the sprite, window near 1023
        start_line(60, 5, 1, 620, 50, t);
        finish_line(t);
        start_line(49, 5, 1, 100, 50, t);
        finish_line(t);
        start_line(10, 9, 1, 1010, 1000, t);
        finish_line(t);

        // Off-screen row: select toggles but nothing is written
        start_line(500, 1, 0, 0, 0, t);
        chk("t4_select", select, exp_sel);
        chk("t4_busy_t1", busy, 0);
        @(negedge Clk);
        chk("t4_busy_t2", busy, 0);
        wait_until(t + 20);
        chk("t4_no_writes", sb.size(), 0);
        chk("t4_write_en", write_en, 0);

        // Overrun mid-fill, then back-to-back accept right after drain
        start_line(20, 6, 0, 0, 0, t);
        wait_until(t + 300);
        line_start = 1'b1;
        @(negedge Clk);
        line_start = 1'b0;
        chk("t5_overrun_pulse", overrun, 1);
        chk("t5_select_held", select, exp_sel);
        @(negedge Clk);
        chk("t5_overrun_clear", overrun, 0);
        finish_line(t);
        start_line(21, 7, 1, 0, 15, t2);
        chk("t5_accept_select", select, exp_sel);
        chk("t5_accept_busy", busy, 1);
        finish_line(t2);

        // Reset mid-fill aborts, then a normal line
        start_line(30, 4, 0, 0, 0, t);
        wait_until(t + 200);
        Reset = 1'b1;
        @(negedge Clk);
        chk("t6_write_en", write_en, 0);
        chk("t6_select", select, 0);
        chk("t6_busy", busy, 0);
        chk("t6_rom_addr", rom_addr, 0);
        sb.delete();
        exp_sel = 0;
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("t6_still_idle", write_en, 0);
        start_line(40, 8, 1, 5, 35, t);
        chk("t6_select_after", select, exp_sel);
        finish_line(t);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
